// File: rtl/i2c_write_bridge.sv
// Queues I2C write bytes as auto-incrementing {addr, data} entries and drains them to a memory write port.
// Request visible 2 clocks after a data_xfc rise; mem_wr_req holds until mem_wr_ack, bytes dropped when full.
module i2c_write_bridge #(
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = 11
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              addr_xfc,
   input  logic [ADDR_W-1:0] i2c_addr,
   input  logic              i2c_RW,
   input  logic              data_xfc,
   input  logic [7:0]        serial_data,
   input  logic              stop_out,
   output logic              mem_wr_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic              mem_wr_ack,
   output logic              busy,
   output logic              overflow,
   output logic [7:0]        byte_count
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [7:0]        dat;
   } entry_t;

   typedef enum logic {IDLE, ARMED} state_t;

   state_t            state;
   state_t            state_nxt;
   logic              addr_xfc_q;
   logic              data_xfc_q;
   logic [ADDR_W-1:0] next_addr;
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [CW-1:0]     count;
   logic [CW-1:0]     count_nxt;
   entry_t            fifo_q [FIFO_DEPTH];

   logic   addr_rise;
   logic   data_rise;
   logic   arm;
   logic   pop;
   logic   push_try;
   logic   fifo_room;
   logic   push_ok;
   logic   drop;
   entry_t push_entry;
   logic   req_nxt;
   logic   load;
   entry_t head_nxt;
   logic   busy_nxt;

   assign addr_rise  = addr_xfc & ~addr_xfc_q;
   assign data_rise  = data_xfc & ~data_xfc_q;
   assign arm        = addr_rise & i2c_RW & ~stop_out;
   assign pop        = mem_wr_req & mem_wr_ack;
   assign push_try   = data_rise & (state == ARMED) & ~stop_out;
   // A full FIFO still takes a byte when the head is leaving on the same edge.
   assign fifo_room  = (count < CW'(FIFO_DEPTH)) | pop;
   assign push_ok    = push_try & fifo_room;
   assign drop       = push_try & ~fifo_room;
   assign push_entry = '{addr: next_addr, dat: serial_data};

   always_comb begin
      count_nxt = count;
      case ({push_ok, pop})
         2'b10:   count_nxt = count + CW'(1);
         2'b01:   count_nxt = count - CW'(1);
         default: count_nxt = count;
      endcase
   end

   always_comb begin
      state_nxt = state;
      if (stop_out)
         state_nxt = IDLE;
      else if (arm)
         state_nxt = ARMED;
   end

   // The output register mirrors the FIFO head; the head entry stays queued until acked.
   always_comb begin
      req_nxt  = mem_wr_req;
      load     = 1'b0;
      head_nxt = fifo_q[rd_ptr];
      if (!mem_wr_req) begin
         if (count != '0) begin
            req_nxt  = 1'b1;
            load     = 1'b1;
            head_nxt = fifo_q[rd_ptr];
         end
      end else if (pop) begin
         if (count > CW'(1)) begin
            req_nxt  = 1'b1;
            load     = 1'b1;
            head_nxt = fifo_q[rd_ptr + PW'(1)];
         end else if (push_ok) begin
            req_nxt  = 1'b1;
            load     = 1'b1;
            head_nxt = push_entry;
         end else begin
            req_nxt = 1'b0;
         end
      end
   end

   assign busy_nxt = (state_nxt == ARMED) | (count_nxt != '0) | req_nxt;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state      <= IDLE;
         addr_xfc_q <= 1'b0;
         data_xfc_q <= 1'b0;
         next_addr  <= '0;
         byte_count <= '0;
         overflow   <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         mem_wr_req <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         busy       <= 1'b0;
      end else begin
         addr_xfc_q <= addr_xfc;
         data_xfc_q <= data_xfc;
         state      <= state_nxt;
         count      <= count_nxt;
         mem_wr_req <= req_nxt;
         busy       <= busy_nxt;
         if (push_ok)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         if (load) begin
            mem_addr  <= head_nxt.addr;
            mem_wdata <= head_nxt.dat;
         end
         if (arm) begin
            next_addr  <= i2c_addr;
            byte_count <= '0;
            overflow   <= 1'b0;
         end else begin
            if (push_ok) begin
               next_addr <= next_addr + ADDR_W'(1);
               if (byte_count != 8'hFF)
                  byte_count <= byte_count + 8'd1;
            end
            if (drop)
               overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (push_ok)
         fifo_q[wr_ptr] <= push_entry;
   end

endmodule

// File: tb/tb_i2c_write_bridge.sv
// Scoreboard bench for i2c_write_bridge: expected writes queued at stimulus time, checked on each handshake.
module tb_i2c_write_bridge;

   logic        Clock = 1'b0;
   logic        Reset = 1'b0;
   logic        addr_xfc = 1'b0;
   logic [10:0] i2c_addr = '0;
   logic        i2c_RW = 1'b0;
   logic        data_xfc = 1'b0;
   logic [7:0]  serial_data = '0;
   logic        stop_out = 1'b1;
   logic        mem_wr_req;
   logic [10:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_wr_ack = 1'b0;
   logic        busy;
   logic        overflow;
   logic [7:0]  byte_count;

   int total = 0;
   int bad   = 0;
   logic [18:0] exp_q[$];

   i2c_write_bridge #(.FIFO_DEPTH(4), .ADDR_W(11)) dut (
      .Clock(Clock), .Reset(Reset), .addr_xfc(addr_xfc), .i2c_addr(i2c_addr),
      .i2c_RW(i2c_RW), .data_xfc(data_xfc), .serial_data(serial_data), .stop_out(stop_out),
      .mem_wr_req(mem_wr_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wr_ack(mem_wr_ack), .busy(busy), .overflow(overflow), .byte_count(byte_count)
   );

   always #5 Clock = ~Clock;

   // Handshake monitor: inputs change just after posedge, so negedge shows what the next edge samples.
   always @(negedge Clock) begin
      if (Reset && mem_wr_req && mem_wr_ack) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write got addr=%h data=%h want none", mem_addr, mem_wdata);
         end else begin
            logic [18:0] e;
            e = exp_q.pop_front();
            if ({mem_addr, mem_wdata} !== e) begin
               bad++;
               $display("FAIL write_entry got addr=%h data=%h want addr=%h data=%h",
                        mem_addr, mem_wdata, e[18:8], e[7:0]);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic arm(input logic [10:0] a);
      stop_out = 1'b0;
      i2c_RW   = 1'b1;
      i2c_addr = a;
      addr_xfc = 1'b1;
      tick();
      addr_xfc = 1'b0;
      tick();
   endtask

   task automatic send_byte(input logic [7:0] d, input int hold);
      serial_data = d;
      data_xfc    = 1'b1;
      repeat (hold) tick();
      data_xfc    = 1'b0;
      serial_data = 8'($urandom);
      tick();
   endtask

   task automatic do_stop();
      stop_out = 1'b1;
      tick();
      stop_out = 1'b0;
      tick();
   endtask

   task automatic wait_drain(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (exp_q.size() == 0 && !mem_wr_req) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      repeat (2) tick();
      total++; if (mem_wr_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", mem_wr_req); end
      total++; if (mem_addr !== 11'h000) begin bad++; $display("FAIL rst_addr got=%h want=000", mem_addr); end
      total++; if (mem_wdata !== 8'h00) begin bad++; $display("FAIL rst_wdata got=%h want=00", mem_wdata); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b want=0", overflow); end
      total++; if (byte_count !== 8'd0) begin bad++; $display("FAIL rst_cnt got=%0d want=0", byte_count); end
      Reset = 1'b1;
      tick();
   endtask

   task automatic test_single_write();
      bit ok;
      mem_wr_ack = 1'b0;
      arm(11'h123);
      exp_q.push_back({11'h123, 8'hA5});
      serial_data = 8'hA5;
      data_xfc    = 1'b1;
      tick();
      total++; if (mem_wr_req !== 1'b0) begin bad++; $display("FAIL single_req_early got=%b want=0", mem_wr_req); end
      data_xfc = 1'b0;
      tick();
      total++; if (mem_wr_req !== 1'b1) begin bad++; $display("FAIL single_req got=%b want=1", mem_wr_req); end
      total++; if (mem_addr !== 11'h123) begin bad++; $display("FAIL single_addr got=%h want=123", mem_addr); end
      total++; if (mem_wdata !== 8'hA5) begin bad++; $display("FAIL single_data got=%h want=a5", mem_wdata); end
      total++; if (byte_count !== 8'd1) begin bad++; $display("FAIL single_cnt got=%0d want=1", byte_count); end
      mem_wr_ack = 1'b1;
      tick();
      mem_wr_ack = 1'b0;
      total++; if (mem_wr_req !== 1'b0) begin bad++; $display("FAIL single_req_drop got=%b want=0", mem_wr_req); end
      wait_drain(ok);
      total++; if (!ok) begin bad++; $display("FAIL single_drain got=pending want=empty"); end
      do_stop();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_idle got=%b want=0", busy); end
   endtask

   task automatic test_burst_wrap();
      bit ok;
      logic [7:0] d [3];
      d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
      mem_wr_ack = 1'b1;
      arm(11'h7FE);
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back({11'(11'h7FE + i), d[i]});
         send_byte(d[i], 1);
      end
      wait_drain(ok);
      total++; if (!ok) begin bad++; $display("FAIL burst_drain got=%0d left want=0", exp_q.size()); end
      total++; if (byte_count !== 8'd3) begin bad++; $display("FAIL burst_cnt got=%0d want=3", byte_count); end
      do_stop();
   endtask

   task automatic test_overflow();
      bit ok;
      mem_wr_ack = 1'b0;
      arm(11'h200);
      for (int i = 0; i < 6; i++) begin
         if (i < 4) exp_q.push_back({11'(11'h200 + i), 8'(i + 1)});
         send_byte(8'(i + 1), 1);
      end
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", overflow); end
      total++; if (byte_count !== 8'd4) begin bad++; $display("FAIL ovf_cnt got=%0d want=4", byte_count); end
      total++; if (mem_wr_req !== 1'b1 || mem_addr !== 11'h200) begin
         bad++; $display("FAIL ovf_head got req=%b addr=%h want req=1 addr=200", mem_wr_req, mem_addr);
      end
      mem_wr_ack = 1'b1;
      wait_drain(ok);
      total++; if (!ok) begin bad++; $display("FAIL ovf_drain got=%0d left want=0", exp_q.size()); end
      repeat (4) tick();
      arm(11'h300);
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", overflow); end
      total++; if (byte_count !== 8'd0) begin bad++; $display("FAIL ovf_cnt_clear got=%0d want=0", byte_count); end
      do_stop();
   endtask

   task automatic test_read_filter();
      bit ok;
      mem_wr_ack = 1'b1;
      stop_out   = 1'b0;
      i2c_RW     = 1'b0;
      i2c_addr   = 11'h155;
      addr_xfc   = 1'b1;
      tick();
      addr_xfc = 1'b0;
      tick();
      send_byte(8'h3C, 1);
      send_byte(8'h4D, 2);
      tick();
      total++; if (mem_wr_req !== 1'b0) begin bad++; $display("FAIL read_req got=%b want=0", mem_wr_req); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL read_busy got=%b want=0", busy); end
      arm(11'h050);
      exp_q.push_back({11'h050, 8'h5A});
      send_byte(8'h5A, 20);
      wait_drain(ok);
      repeat (3) tick();
      total++; if (!ok) begin bad++; $display("FAIL hold_drain got=%0d left want=0", exp_q.size()); end
      total++; if (byte_count !== 8'd1) begin bad++; $display("FAIL hold_cnt got=%0d want=1", byte_count); end
      do_stop();
   endtask

   task automatic test_stop_vs_byte();
      mem_wr_ack = 1'b1;
      arm(11'h010);
      stop_out    = 1'b1;
      serial_data = 8'hEE;
      data_xfc    = 1'b1;
      tick();
      stop_out = 1'b0;
      data_xfc = 1'b0;
      repeat (4) tick();
      total++; if (mem_wr_req !== 1'b0) begin bad++; $display("FAIL stopbyte_req got=%b want=0", mem_wr_req); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL stopbyte_ovf got=%b want=0", overflow); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL stopbyte_busy got=%b want=0", busy); end
   endtask

   task automatic test_stop_restart();
      bit ok;
      mem_wr_ack = 1'b0;
      arm(11'h0A0);
      exp_q.push_back({11'h0A0, 8'hB1});
      send_byte(8'hB1, 1);
      exp_q.push_back({11'h0A1, 8'hB2});
      send_byte(8'hB2, 1);
      do_stop();
      repeat (5) tick();
      total++; if (mem_wr_req !== 1'b1 || busy !== 1'b1) begin
         bad++; $display("FAIL stop_pending got req=%b busy=%b want req=1 busy=1", mem_wr_req, busy);
      end
      mem_wr_ack = 1'b1;
      wait_drain(ok);
      total++; if (!ok) begin bad++; $display("FAIL stop_drain got=%0d left want=0", exp_q.size()); end
      arm(11'h040);
      exp_q.push_back({11'h040, 8'hC7});
      send_byte(8'hC7, 1);
      total++; if (byte_count !== 8'd1) begin bad++; $display("FAIL restart_cnt got=%0d want=1", byte_count); end
      wait_drain(ok);
      total++; if (!ok) begin bad++; $display("FAIL restart_drain got=%0d left want=0", exp_q.size()); end
      do_stop();
   endtask

   task automatic test_reset_mid();
      bit ok;
      mem_wr_ack = 1'b0;
      arm(11'h100);
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back({11'(11'h100 + i), 8'(8'h80 + i)});
         send_byte(8'(8'h80 + i), 1);
      end
      total++; if (mem_wr_req !== 1'b1) begin bad++; $display("FAIL mid_req_before got=%b want=1", mem_wr_req); end
      Reset = 1'b0;
      #1;
      total++; if ({mem_wr_req, busy, overflow} !== 3'b000) begin
         bad++; $display("FAIL mid_flags got req=%b busy=%b ovf=%b want 0", mem_wr_req, busy, overflow);
      end
      total++; if (mem_addr !== 11'h000 || mem_wdata !== 8'h00 || byte_count !== 8'd0) begin
         bad++; $display("FAIL mid_values got addr=%h data=%h cnt=%0d want 0", mem_addr, mem_wdata, byte_count);
      end
      exp_q.delete();
      repeat (2) tick();
      Reset      = 1'b1;
      mem_wr_ack = 1'b1;
      repeat (5) tick();
      send_byte(8'h77, 1);
      repeat (4) tick();
      total++; if (mem_wr_req !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL mid_after got req=%b busy=%b want 0", mem_wr_req, busy);
      end
      arm(11'h321);
      exp_q.push_back({11'h321, 8'h99});
      send_byte(8'h99, 1);
      wait_drain(ok);
      total++; if (!ok) begin bad++; $display("FAIL mid_rearm_drain got=%0d left want=0", exp_q.size()); end
      do_stop();
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_burst_wrap();
      test_overflow();
      test_read_filter();
      test_stop_vs_byte();
      test_stop_restart();
      test_reset_mid();
      repeat (3) tick();
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL leftover got=%0d want=0", exp_q.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
